scan_decoder: RTL
=================

SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 SHALL have parameter IN_W, default 4, select width; output width is 2**IN_W.
REQ-002 SHALL have parameter STEP_DIV, default 1, clocks per scan step; legal range >= 1.
REQ-003 SHALL have parameter ACTIVE_LOW, default 0; 1 inverts every bit of dout (active line = 0, inactive = 1).
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous reset, active-high.
REQ-007 en  input  1  enable; 0 = all outputs inactive, state frozen.
REQ-008 mode  input  1  0 = direct decode, 1 = scan.
REQ-009 load  input  1  1-cycle strobe; loads din into index.
REQ-010 din  input  IN_W  select value or scan start index.
REQ-011 dout  output  2**IN_W  registered one-hot decode of idx, polarity per ACTIVE_LOW.
REQ-012 idx  output  IN_W  current registered index.
REQ-013 wrap  output  1  1-cycle pulse on scan wrap-around.

Function
REQ-014 dout, idx and wrap SHALL be registered; no combinational path from inputs to outputs.
REQ-015 "Active dout" means bit idx active, all other bits inactive; "inactive dout" means all bits inactive.
REQ-016 Priority per edge: rst > load > mode behaviour.
REQ-017 load=1: idx <= din; divider <= 0; wrap <= 0; dout <= one-hot(din) if en=1, else inactive. Same in both modes.
REQ-018 Mode 0, en=1, load=0: idx <= din; dout <= one-hot(din); latency exactly 1 clock; wrap <= 0.
REQ-019 Mode 0: divider held at 0.
REQ-020 Mode 1, en=1, load=0: divider counts 0..STEP_DIV-1; when divider = STEP_DIV-1, divider <= 0 and idx <= idx+1 mod 2**IN_W; otherwise idx holds.
REQ-021 Mode 1, en=1: dout SHALL always be one-hot of the registered idx (updated in the same edge as idx).
REQ-022 wrap SHALL be 1 for exactly the cycle after idx steps from 2**IN_W-1 to 0 in scan; 0 otherwise. A load to 0 SHALL NOT raise wrap.
REQ-023 STEP_DIV=1: idx SHALL advance every enabled cycle.
REQ-024 en=0 (load=0): idx and divider hold; dout inactive; wrap 0. On return to en=1, scan resumes from the frozen idx/divider with no lost or extra step.
REQ-025 Mode change 1->0: next edge follows REQ-018. Mode change 0->1: scan starts from current idx with divider = 0; first step after STEP_DIV enabled cycles.
REQ-026 Arithmetic: idx increment is modulo 2**IN_W, no overflow flag; divider width ceil(log2(STEP_DIV)), minimum 1 bit.

Reset
REQ-027 rst=1 at an edge: idx <= 0, divider <= 0, wrap <= 0, dout <= inactive (all 0, or all 1 if ACTIVE_LOW); overrides load, en, mode.
REQ-028 rst asserted mid-scan SHALL abort the scan; after release with mode=1, en=1, scan restarts at idx 0 and first step occurs after STEP_DIV cycles.

Verification (IN_W=4 unless stated)
REQ-029 Reset: rst=1 for 2 cycles with en=1, mode=1, load=1, din=9 -> idx=0, dout=16'h0000, wrap=0; with ACTIVE_LOW=1, dout=16'hFFFF.
REQ-030 Direct: mode=0, en=1, din=5 then 12 on consecutive cycles -> dout=16'h0020 then 16'h1000, each 1 clock after din; idx=5 then 12.
REQ-031 Scan with wrap: STEP_DIV=3, load din=14, then mode=1, en=1 -> idx 14,14,14,15,15,15,0 ...; wrap=1 only in the single cycle idx first shows 0; dout tracks 16'h4000, 16'h8000, 16'h0001.
REQ-032 Freeze: STEP_DIV=3, scanning with idx=7 and divider=1, drop en for 5 cycles -> dout=16'h0000, idx=7; re-enable -> idx steps to 8 after exactly 2 enabled cycles.
REQ-033 Load mid-scan: STEP_DIV=1, scanning at idx=3, load=1, din=10 -> next idx=10, dout=16'h0400, then 11, 12 on following cycles; no wrap pulse.
REQ-034 Reset mid-scan: STEP_DIV=2, rst pulsed at idx=9 -> idx=0, dout=16'h0001 on first enabled post-reset cycle; idx=1 two cycles later.

Source files
------------

// File: rtl/scan_decoder_if.sv
// ---------------------------------------------------------------------------
// scan_decoder_if
// Groups the control/select inputs and the decoded outputs of scan_decoder.
//   en    : enable (0 = outputs inactive, state frozen)
//   mode  : 0 = direct decode, 1 = scan
//   load  : one-cycle strobe loading din into the index
//   din   : select value / scan start index
//   dout  : registered one-hot decode of idx
//   idx   : current registered index
//   wrap  : one-cycle pulse when the scan wraps to index 0
// master drives the controls, slave (the decoder) drives the results.
// ---------------------------------------------------------------------------
interface scan_decoder_if #(
    parameter int IN_W = 4
);
    logic                     en;
    logic                     mode;
    logic                     load;
    logic [IN_W-1:0]          din;
    logic [(2**IN_W)-1:0]     dout;
    logic [IN_W-1:0]          idx;
    logic                     wrap;

    modport master (
        output en, mode, load, din,
        input  dout, idx, wrap
    );

    modport slave (
        input  en, mode, load, din,
        output dout, idx, wrap
    );
endinterface

// File: rtl/scan_decoder.sv
// ---------------------------------------------------------------------------
// scan_decoder
// One-hot decoder with an optional self-advancing scan.
//   mode 0 : dout shows the one-hot decode of din one clock later.
//   mode 1 : idx advances by one every STEP_DIV enabled clocks (modulo
//            2**IN_W); wrap pulses for the cycle after idx rolls over to 0.
//   load   : forces idx to din and restarts the step divider.
//   en = 0 : outputs inactive, idx and divider frozen.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : scan_decoder_if slave (en, mode, load, din -> dout, idx, wrap)
// Parameters: IN_W (select width), STEP_DIV (clocks per scan step, >= 1),
//             ACTIVE_LOW (1 = inverted dout polarity).
// ---------------------------------------------------------------------------
module scan_decoder #(
    parameter int IN_W       = 4,
    parameter int STEP_DIV   = 1,
    parameter int ACTIVE_LOW = 0
) (
    input  logic           clk,
    input  logic           rst,
    scan_decoder_if.slave  bus
);
    localparam int OUT_W = 2**IN_W;
    localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
    localparam logic [IN_W-1:0]  IDX_LAST = {IN_W{1'b1}};
    // XOR mask applied to every dout value; also the "inactive" pattern.
    localparam logic [OUT_W-1:0] POL_MASK = (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

    logic [IN_W-1:0]  r_idx;
    logic [DIV_W-1:0] r_div;
    logic             r_wrap;
    logic [OUT_W-1:0] r_dout;

    logic [IN_W-1:0]  w_idx_nxt;
    logic [DIV_W-1:0] w_div_nxt;
    logic             w_wrap_nxt;
    logic [OUT_W-1:0] w_dout_nxt;

    // One-hot of sel when active, all-zero otherwise, then polarity applied.
    function automatic logic [OUT_W-1:0] f_decode(input logic [IN_W-1:0] sel, input logic active);
        logic [OUT_W-1:0] v;
        v      = {OUT_W{1'b0}};
        v[sel] = active;
        return v ^ POL_MASK;
    endfunction

    // Next-state selection: load beats enable/mode behaviour.
    always_comb begin
        w_idx_nxt  = r_idx;
        w_div_nxt  = r_div;
        w_wrap_nxt = 1'b0;
        w_dout_nxt = POL_MASK;
        if (bus.load) begin
            w_idx_nxt  = bus.din;
            w_div_nxt  = {DIV_W{1'b0}};
            w_dout_nxt = f_decode(bus.din, bus.en);
        end else if (!bus.en) begin
            // Frozen: idx/divider keep their values so the scan resumes exactly.
            w_idx_nxt  = r_idx;
            w_div_nxt  = r_div;
            w_dout_nxt = POL_MASK;
        end else if (!bus.mode) begin
            w_idx_nxt  = bus.din;
            w_div_nxt  = {DIV_W{1'b0}};
            w_dout_nxt = f_decode(bus.din, 1'b1);
        end else begin
            if (r_div == DIV_LAST) begin
                w_div_nxt  = {DIV_W{1'b0}};
                w_idx_nxt  = r_idx + IN_W'(1);
                w_wrap_nxt = (r_idx == IDX_LAST);
            end else begin
                w_div_nxt  = r_div + DIV_W'(1);
                w_idx_nxt  = r_idx;
            end
            // dout follows the index being registered on this same edge.
            w_dout_nxt = f_decode(w_idx_nxt, 1'b1);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx  <= {IN_W{1'b0}};
            r_div  <= {DIV_W{1'b0}};
            r_wrap <= 1'b0;
            r_dout <= POL_MASK;
        end else begin
            r_idx  <= w_idx_nxt;
            r_div  <= w_div_nxt;
            r_wrap <= w_wrap_nxt;
            r_dout <= w_dout_nxt;
        end
    end

    assign bus.idx  = r_idx;
    assign bus.dout = r_dout;
    assign bus.wrap = r_wrap;
endmodule
